// File: rtl/serial_loader_pkg.sv
// Shared definitions for the serial candidate loader: FSM state encoding
// and the width of the completed-handshake counter.
package serial_loader_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam int LOADED_COUNT_W = 8;

endpackage : serial_loader_pkg

// File: rtl/serial_loader_sipo_shift.sv
// Serial-in parallel-out shift register with its accepted-bit counter.
// The counter signals when the next accepted bit completes the word.
module sipo_shift #(
  parameter int NBITS = 31
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [NBITS-1:0] value,
  output logic             last
);

  localparam int CNT_W = $clog2(NBITS + 1);

  logic [CNT_W-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
      count <= '0;
    end else if (clear) begin
      value <= '0;
      count <= '0;
    end else if (shift_en) begin
      value <= {value[NBITS-2:0], bit_in};
      count <= count + CNT_W'(1);
    end
  end

  // The owner stops shifting once the word is full, so count tops out at NBITS.
  assign last = (count == CNT_W'(NBITS - 1));

endmodule : sipo_shift

// File: rtl/serial_loader.sv
// Assembles an NBITS-wide candidate from a MSB-first bit stream and presents
// it with a valid/ready handshake; counts completed handshakes modulo 256.
module serial_loader
  import serial_loader_pkg::*;
#(
  parameter int NBITS = 31
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      ser_data,
  input  logic                      ser_valid,
  output logic                      ser_ready,
  input  logic                      ser_clear,
  output logic [NBITS-1:0]          num,
  output logic                      num_valid,
  input  logic                      num_ready,
  output logic [LOADED_COUNT_W-1:0] loaded_count
);

  state_t state, state_next;
  logic   accept;
  logic   handshake;
  logic   last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= COLLECT;
    else          state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    accept     = (state == COLLECT) && ser_valid;
    handshake  = (state == HOLD) && num_ready;
    if (ser_clear) begin
      state_next = COLLECT;
    end else begin
      unique case (state)
        COLLECT: if (accept && last) state_next = HOLD;
        HOLD:    if (handshake)      state_next = COLLECT;
        default: state_next = COLLECT;
      endcase
    end
  end

  // Pure state decodes keep both handshake outputs free of input paths.
  assign ser_ready = (state == COLLECT);
  assign num_valid = (state == HOLD);

  sipo_shift #(.NBITS(NBITS)) u_sipo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (ser_clear || handshake),
    .shift_en(accept),
    .bit_in  (ser_data),
    .value   (num),
    .last    (last)
  );

  // A clear discards the held candidate, so it never counts as a handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    loaded_count <= '0;
    else if (handshake && !ser_clear) loaded_count <= loaded_count + LOADED_COUNT_W'(1);
  end

endmodule : serial_loader
